// File: rtl/spi_adc_slave_if.sv
// Bus bundle between an SPI master and the emulated 8-channel ADC.
// Carries the SPI pins, the parallel channel samples and the status/decode outputs.
interface spi_adc_slave_if #(
    parameter int NCH = 8
);
    logic                 sclk;
    logic                 cs;
    logic                 simo;
    logic                 somi;
    logic [16*NCH-1:0]    ch_data;
    logic [11:0]          cfr;
    logic                 cfr_wr;
    logic [15:0]          cmd;
    logic                 cmd_valid;
    logic                 frame_err;
    logic                 busy;
    logic [2:0]           sel;

    modport slave (
        input  sclk, cs, simo, ch_data,
        output somi, cfr, cfr_wr, cmd, cmd_valid, frame_err, busy, sel
    );

    modport master (
        output sclk, cs, simo, ch_data,
        input  somi, cfr, cfr_wr, cmd, cmd_valid, frame_err, busy, sel
    );
endinterface

// File: rtl/spi_adc_slave.sv
// SPI responder emulating an 8-channel ADC: 16-bit CS-framed commands in, previous result out.
// Optional CFR_READBACK_EN: opcode 0xC loads {4'hA, cfr} as the next frame's result.
module spi_adc_slave #(
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    spi_adc_slave_if.slave  bus
);
    localparam int S = SYNC_STAGES;

    typedef enum logic [1:0] {ARM, IDLE, SHIFT, DONE} state_e;

    state_e        state_q, state_d;
    logic [S:0]    cs_q, sclk_q, vld_pipe;
    logic [S-1:0]  simo_q;
    logic [15:0]   rx_q, tx_q, result_q, cmd_q;
    logic [4:0]    bit_cnt_q;
    logic [11:0]   cfr_q;
    logic [2:0]    sel_q;
    logic          somi_q, cmd_valid_q, cfr_wr_q, frame_err_q;

    logic          cs_s, simo_s, cs_rise, cs_fall, sclk_rise, sclk_fall;
    logic [3:0]    op;
    logic [15:0]   ch_word;

    // Bit S of each chain is the previous synced sample, used only for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cs_q     <= '1;
            sclk_q   <= '0;
            simo_q   <= '0;
            vld_pipe <= '0;
        end else begin
            cs_q     <= {cs_q[S-1:0], bus.cs};
            sclk_q   <= {sclk_q[S-1:0], bus.sclk};
            vld_pipe <= {vld_pipe[S-1:0], 1'b1};
            simo_q[0] <= bus.simo;
            for (int i = 1; i < S; i++) simo_q[i] <= simo_q[i-1];
        end
    end

    always_comb begin
        cs_s      = cs_q[S-1];
        simo_s    = simo_q[S-1];
        cs_rise   =  cs_q[S-1] & ~cs_q[S];
        cs_fall   = ~cs_q[S-1] &  cs_q[S];
        sclk_rise =  sclk_q[S-1] & ~sclk_q[S];
        sclk_fall = ~sclk_q[S-1] &  sclk_q[S];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ARM;
        else         state_q <= state_d;
    end

    // ARM waits for the synchronizers to hold real samples so a frame cut by reset is skipped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARM:     if (vld_pipe[S] && cs_s) state_d = IDLE;
            IDLE:    if (cs_fall)             state_d = SHIFT;
            SHIFT:   if (cs_rise)             state_d = DONE;
            DONE:                             state_d = IDLE;
            default:                          state_d = ARM;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q == SHIFT);
        bus.somi      = somi_q;
        bus.cfr       = cfr_q;
        bus.cfr_wr    = cfr_wr_q;
        bus.cmd       = cmd_q;
        bus.cmd_valid = cmd_valid_q;
        bus.frame_err = frame_err_q;
        bus.sel       = sel_q;
    end

    always_comb begin
        op      = rx_q[15:12];
        ch_word = '0;
        for (int k = 0; k < NCH; k++)
            if (int'(op) == k) ch_word = bus.ch_data[16*k +: 16];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_q        <= '0;
            tx_q        <= '0;
            result_q    <= '0;
            cmd_q       <= '0;
            bit_cnt_q   <= '0;
            cfr_q       <= '0;
            sel_q       <= '0;
            somi_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cfr_wr_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            cfr_wr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: if (cs_fall) begin
                    tx_q      <= result_q;
                    somi_q    <= result_q[15];
                    bit_cnt_q <= '0;
                end
                // cs edge wins over a coincident sclk edge
                SHIFT: if (cs_rise) begin
                    somi_q <= 1'b0;
                end else begin
                    if (sclk_rise) begin
                        rx_q <= {rx_q[14:0], simo_s};
                        if (bit_cnt_q != 5'd31) bit_cnt_q <= bit_cnt_q + 5'd1;
                    end
                    if (sclk_fall && bit_cnt_q >= 5'd1 && bit_cnt_q <= 5'd15) begin
                        tx_q   <= {tx_q[14:0], 1'b0};
                        somi_q <= tx_q[14];
                    end
                end
                DONE: begin
                    somi_q <= 1'b0;
                    if (bit_cnt_q == 5'd16) begin
                        cmd_q       <= rx_q;
                        cmd_valid_q <= 1'b1;
                        if (int'(op) < NCH) begin
                            result_q <= ch_word;
                            sel_q    <= op[2:0];
                        end else if (op == 4'hA) begin
                            cfr_q    <= rx_q[11:0];
                            cfr_wr_q <= 1'b1;
                        end
`ifdef CFR_READBACK_EN
                        else if (op == 4'hC) begin
                            result_q <= {4'hA, cfr_q};
                        end
`endif
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end
                default: somi_q <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_adc_slave.sv
// Bench for spi_adc_slave: directed table, coincident-edge and mid-frame-reset sequences, random frames.
module tb_spi_adc_slave;
    localparam int NCH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_adc_slave_if #(.NCH(NCH)) bus();
    spi_adc_slave #(.NCH(NCH), .SYNC_STAGES(2)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    int n_chk = 0, n_fail = 0;
    int n_cv = 0, n_err = 0, n_cfrwr = 0;
    int m_ncv = 0, m_nerr = 0, m_ncfr = 0;
    logic [15:0] m_result = '0, m_cmd = '0;
    logic [11:0] m_cfr = '0;
    logic [15:0] chd [NCH];

    typedef struct {
        logic [15:0] w;
        int          nb;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [11];

    always @(negedge clk) begin
        if (bus.cmd_valid) n_cv++;
        if (bus.frame_err) n_err++;
        if (bus.cfr_wr)    n_cfrwr++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_ch();
        for (int k = 0; k < NCH; k++) bus.ch_data[16*k +: 16] = chd[k];
    endtask

    // Reference: a 16-bit frame executes its command; any other length only flags an error.
    task automatic model_frame(input logic [15:0] w, input int nb);
        logic [3:0] op;
        op = w[15:12];
        if (nb == 16) begin
            m_cmd = w;
            m_ncv++;
            if (int'(op) < NCH) m_result = chd[op[2:0]];
            else if (op == 4'hA) begin
                m_cfr = w[11:0];
                m_ncfr++;
            end
`ifdef CFR_READBACK_EN
            else if (op == 4'hC) m_result = {4'hA, m_cfr};
`endif
        end else begin
            m_nerr++;
        end
    endtask

    task automatic clock_bit(input logic b, output logic s);
        bus.simo = b;
        repeat (4) @(negedge clk);
        s = bus.somi;
        bus.sclk = 1'b1;
        repeat (4) @(negedge clk);
        bus.sclk = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] w, input int nb, input bit coinc, output logic [15:0] got);
        logic s;
        got = '0;
        @(negedge clk);
        bus.cs = 1'b0;
        if (coinc) bus.sclk = 1'b1;
        repeat (4) @(negedge clk);
        bus.sclk = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_in_frame", 32'(bus.busy), 32'd1);
        for (int i = 0; i < nb; i++) begin
            clock_bit((i < 16) ? w[15-i] : 1'b0, s);
            if (i < 16) got = {got[14:0], s};
        end
        repeat (4) @(negedge clk);
        bus.cs = 1'b1;
        if (coinc) bus.sclk = 1'b1;
        repeat (4) @(negedge clk);
        bus.sclk = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_frame(input logic [15:0] w, input int nb, input bit coinc, output logic [15:0] got);
        logic [15:0] exp_ret;
        exp_ret = (nb >= 16) ? m_result : (m_result >> (16 - nb));
        run_frame(w, nb, coinc, got);
        model_frame(w, nb);
        chk("somi_word", 32'(got), 32'(exp_ret));
        chk("cmd", 32'(bus.cmd), 32'(m_cmd));
        chk("cfr", 32'(bus.cfr), 32'(m_cfr));
        chk("cmd_valid_cnt", 32'(n_cv), 32'(m_ncv));
        chk("frame_err_cnt", 32'(n_err), 32'(m_nerr));
        chk("cfr_wr_cnt", 32'(n_cfrwr), 32'(m_ncfr));
        chk("somi_idle", 32'(bus.somi), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [15:0] got, w;
        logic s;
        int nb, cv0, err0;

        bus.cs = 1'b1; bus.sclk = 1'b0; bus.simo = 1'b0;
        for (int k = 0; k < NCH; k++) chd[k] = '0;
        chd[0] = 16'h1234;
        chd[1] = 16'hBEEF;
        load_ch();

        tbl[0]  = '{16'hA000, 16, 16'h0000};
        tbl[1]  = '{16'hAA00, 16, 16'h0000};
        tbl[2]  = '{16'h0000, 16, 16'h0000};
        tbl[3]  = '{16'h1000, 16, 16'h1234};
        tbl[4]  = '{16'h0000, 16, 16'hBEEF};
        tbl[5]  = '{16'h1000, 12, 16'h0123};
        tbl[6]  = '{16'h0000, 20, 16'h1234};
        tbl[7]  = '{16'h1000, 16, 16'h1234};
        tbl[8]  = '{16'hA5A5, 16, 16'hBEEF};
        tbl[9]  = '{16'hC000, 16, 16'hBEEF};
`ifdef CFR_READBACK_EN
        tbl[10] = '{16'h0000, 16, 16'hA5A5};
`else
        tbl[10] = '{16'h0000, 16, 16'hBEEF};
`endif

        repeat (3) @(negedge clk);
        chk("rst_somi", 32'(bus.somi), 32'd0);
        chk("rst_cfr", 32'(bus.cfr), 32'd0);
        chk("rst_cmd", 32'(bus.cmd), 32'd0);
        chk("rst_pulses", 32'({bus.cmd_valid, bus.cfr_wr, bus.frame_err, bus.busy}), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            do_frame(tbl[i].w, tbl[i].nb, 1'b0, got);
            chk($sformatf("tbl%0d_somi", i), 32'(got), 32'(tbl[i].exp));
            if (i == 1) chk("cfr_after_AA00", 32'(bus.cfr), 32'h0A00);
        end
        chk("err_pulses_total", 32'(n_err), 32'd2);

        // cs/sclk coincident at both frame ends: both coincident sclk edges are dropped
        do_frame(16'h1000, 16, 1'b1, got);
        chk("coinc_somi", 32'(got), 32'h1234);
        chk("coinc_cmd", 32'(bus.cmd), 32'h1000);

        // reset in the middle of a frame with cs held low
        cv0 = n_cv; err0 = n_err;
        @(negedge clk);
        bus.cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 7; i++) clock_bit(1'b1, s);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_result = '0; m_cfr = '0; m_cmd = '0;
        chk("midrst_cmd", 32'(bus.cmd), 32'd0);
        chk("midrst_cfr", 32'(bus.cfr), 32'd0);
        for (int i = 0; i < 9; i++) clock_bit(1'b0, s);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        repeat (4) @(negedge clk);
        bus.cs = 1'b1;
        repeat (14) @(negedge clk);
        chk("midrst_no_cmd_valid", 32'(n_cv), 32'(cv0));
        chk("midrst_no_err", 32'(n_err), 32'(err0));
        chd[5] = 16'h00FF;
        load_ch();
        do_frame(16'h5000, 16, 1'b0, got);
        chk("ch5_first", 32'(got), 32'h0000);
        chk("sel5", 32'(bus.sel), 32'd5);
        do_frame(16'h0000, 16, 1'b0, got);
        chk("ch5_return", 32'(got), 32'h00FF);

        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < NCH; k++) chd[k] = 16'($urandom);
            load_ch();
            w = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       nb = 15;
                1:       nb = 17;
                2:       nb = 8;
                default: nb = 16;
            endcase
            do_frame(w, nb, ($urandom_range(0, 3) == 0), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
